// File: rtl/peripheral_timer.sv
// Memory-mapped timer/systick responder on the MEM-stage data bus; drives CPU IRQ.
// Optional prescaler (PSC register + hidden PCNT) enabled by defining TIMER_PRESCALE_EN.
module peripheral_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter logic [31:0] TH_RST    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        IRQ
);

  localparam logic [2:0] OFF_TH   = 3'd0;
  localparam logic [2:0] OFF_TL   = 3'd1;
  localparam logic [2:0] OFF_TCON = 3'd2;
  localparam logic [2:0] OFF_PSC  = 3'd3;
  localparam logic [2:0] OFF_TICK = 3'd5;

  logic [31:0] r_th;
  logic [31:0] r_tl;
  logic [31:0] r_tick;
  logic        r_en;
  logic        r_ie;
  logic        r_stat;

  logic        w_hit;
  logic [2:0]  w_off;
  logic        w_wr_th;
  logic        w_wr_tl;
  logic        w_wr_tcon;
  logic        w_step;
  logic        w_ovf;
  logic        w_unused;

  assign w_hit     = (Addr[31:5] == BASE_ADDR[31:5]);
  assign w_off     = Addr[4:2];
  assign w_unused  = &{1'b0, Addr[1:0]};
  assign w_wr_th   = MemWr && w_hit && (w_off == OFF_TH);
  assign w_wr_tl   = MemWr && w_hit && (w_off == OFF_TL);
  assign w_wr_tcon = MemWr && w_hit && (w_off == OFF_TCON);

`ifdef TIMER_PRESCALE_EN
  logic [31:0] r_psc;
  logic [31:0] r_pcnt;
  logic        w_wr_psc;
  logic        w_en_rise;

  assign w_wr_psc  = MemWr && w_hit && (w_off == OFF_PSC);
  assign w_en_rise = w_wr_tcon && WriteData[0] && !r_en;
  assign w_step    = r_en && (r_pcnt == r_psc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_psc  <= '0;
      r_pcnt <= '0;
    end else begin
      if (w_wr_psc) r_psc <= WriteData;
      // A new prescale value or a fresh enable restarts the divide phase
      if (w_wr_psc || w_en_rise) r_pcnt <= '0;
      else if (r_en)             r_pcnt <= (r_pcnt == r_psc) ? 32'd0 : r_pcnt + 32'd1;
    end
  end
`else
  assign w_step = r_en;
`endif

  assign w_ovf = w_step && (r_tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_th   <= TH_RST;
      r_tl   <= '0;
      r_tick <= '0;
      r_en   <= 1'b0;
      r_ie   <= 1'b0;
      r_stat <= 1'b0;
    end else begin
      r_tick <= r_tick + 32'd1;
      if (w_wr_th) r_th <= WriteData;
      // Reload uses the pre-edge TH even if TH is written on the same edge
      if (w_wr_tl)     r_tl <= WriteData;
      else if (w_step) r_tl <= w_ovf ? r_th : r_tl + 32'd1;
      if (w_wr_tcon) begin
        r_en   <= WriteData[0];
        r_ie   <= WriteData[1];
        r_stat <= WriteData[2] | (w_ovf & r_ie);
      end else if (w_ovf && r_ie) begin
        r_stat <= 1'b1;
      end
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRd && w_hit) begin
      case (w_off)
        OFF_TH:   ReadData = r_th;
        OFF_TL:   ReadData = r_tl;
        OFF_TCON: ReadData = {29'd0, r_stat, r_ie, r_en};
`ifdef TIMER_PRESCALE_EN
        OFF_PSC:  ReadData = r_psc;
`endif
        OFF_TICK: ReadData = r_tick;
        default:  ReadData = '0;
      endcase
    end
  end

  assign IRQ = r_ie & r_stat;

endmodule

// File: tb/tb_peripheral_timer.sv
// Directed bench for peripheral_timer: reference model compared every cycle,
// plus literal expectations. Honours TIMER_PRESCALE_EN the same way as the design.
module tb_peripheral_timer;

  localparam logic [31:0] BASE   = 32'h4000_0000;
  localparam logic [31:0] A_TH   = BASE + 32'h00;
  localparam logic [31:0] A_TL   = BASE + 32'h04;
  localparam logic [31:0] A_TCON = BASE + 32'h08;
  localparam logic [31:0] A_PSC  = BASE + 32'h0C;
  localparam logic [31:0] A_TICK = BASE + 32'h14;

  logic        clk;
  logic        reset;
  logic        MemRd;
  logic        MemWr;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        IRQ;

  int n_checks = 0;
  int n_errors = 0;

  peripheral_timer #(.BASE_ADDR(BASE), .TH_RST(32'h0)) dut (
    .clk(clk), .reset(reset), .MemRd(MemRd), .MemWr(MemWr), .Addr(Addr),
    .WriteData(WriteData), .ReadData(ReadData), .IRQ(IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] m_th, m_tl, m_tick, m_psc, m_pcnt;
  logic        m_en, m_ie, m_stat;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic rd, input logic [31:0] a);
    if (!rd || a[31:5] != BASE[31:5]) return 32'h0;
    case (a[4:0] & 5'h1C)
      5'h00: return m_th;
      5'h04: return m_tl;
      5'h08: return {29'd0, m_stat, m_ie, m_en};
`ifdef TIMER_PRESCALE_EN
      5'h0C: return m_psc;
`endif
      5'h14: return m_tick;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic        hit, adv, wrap;
    logic [4:0]  off;
    logic [31:0] th_n, tl_n, psc_n, pcnt_n;
    logic        en_n, ie_n, stat_n;
    hit = (Addr[31:5] == BASE[31:5]) && MemWr;
    off = Addr[4:0] & 5'h1C;
    adv = m_en;
`ifdef TIMER_PRESCALE_EN
    adv = m_en && (m_pcnt == m_psc);
`endif
    wrap = adv && (m_tl == 32'hFFFF_FFFF);
    th_n = m_th; tl_n = m_tl; psc_n = m_psc; pcnt_n = m_pcnt;
    en_n = m_en; ie_n = m_ie; stat_n = m_stat;
    if (adv)  tl_n = wrap ? m_th : m_tl + 1;
    if (wrap && m_ie) stat_n = 1'b1;
    if (m_en) pcnt_n = (m_pcnt == m_psc) ? 0 : m_pcnt + 1;
    if (hit && off == 5'h00) th_n = WriteData;
    if (hit && off == 5'h04) tl_n = WriteData;
    if (hit && off == 5'h08) begin
      if (WriteData[0] && !m_en) pcnt_n = 0;
      en_n   = WriteData[0];
      ie_n   = WriteData[1];
      stat_n = WriteData[2] || (wrap && m_ie);
    end
`ifdef TIMER_PRESCALE_EN
    if (hit && off == 5'h0C) begin
      psc_n  = WriteData;
      pcnt_n = 0;
    end
`endif
    m_th = th_n; m_tl = tl_n; m_psc = psc_n; m_pcnt = pcnt_n;
    m_en = en_n; m_ie = ie_n; m_stat = stat_n;
    m_tick = m_tick + 1;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_th = 32'h0; m_tl = 0; m_tick = 0; m_psc = 0; m_pcnt = 0;
      m_en = 0; m_ie = 0; m_stat = 0;
    end else begin
      model_edge();
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check32("model_irq", {31'd0, IRQ}, {31'd0, m_ie & m_stat});
      check32("model_rdata", ReadData, model_rd(MemRd, Addr));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    Addr = a; WriteData = d; MemWr = 1'b1;
    cyc();
    MemWr = 1'b0;
  endtask

  // Literal read check, then hold the read over the next negedge for the model compare
  task automatic chk_rd(input string name, input logic [31:0] a, input logic [31:0] exp);
    Addr = a; MemRd = 1'b1;
    #1;
    check32(name, ReadData, exp);
    @(negedge clk);
    #1;
    MemRd = 1'b0;
  endtask

  task automatic probe(input logic [31:0] a);
    Addr = a; MemRd = 1'b1;
    @(negedge clk);
    #1;
    MemRd = 1'b0;
  endtask

  task automatic chk_irq(input string name, input logic exp);
    check32(name, {31'd0, IRQ}, {31'd0, exp});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; MemRd = 1'b0; MemWr = 1'b0; Addr = '0; WriteData = '0;
    #12 reset = 1'b1;
    cyc();
    chk_rd("rst_th", A_TH, 32'h0);
    chk_rd("rst_tcon", A_TCON, 32'h0);
    chk_irq("rst_irq", 1'b0);

    // Reload and interrupt timing
    wr(A_TH, 32'hFFFF_FFFC);
    wr(A_TL, 32'hFFFF_FFFD);
    wr(A_TCON, 32'h3);
    chk_irq("rl_irq_e0", 1'b0);
    cyc(); chk_irq("rl_irq_e1", 1'b0);
    cyc(); chk_irq("rl_irq_e2", 1'b0);
    cyc(); chk_irq("rl_irq_e3", 1'b1);
    chk_rd("rl_tl", A_TL, 32'hFFFF_FFFC);
    wr(A_TCON, 32'h3);
    chk_irq("clr_irq", 1'b0);
    chk_rd("clr_tl", A_TL, 32'hFFFF_FFFD);

    // TCON write colliding with overflow
    cyc(); cyc();
    chk_rd("col_pre_tl", A_TL, 32'hFFFF_FFFF);
    wr(A_TCON, 32'h3);
    chk_irq("col_irq", 1'b1);
    chk_rd("col_tcon", A_TCON, 32'h7);
    chk_rd("col_tl", A_TL, 32'hFFFF_FFFC);

    // Asynchronous reset mid-count
    wr(A_TL, 32'h55);
    cyc();
    chk_rd("pre_rst_tl", A_TL, 32'h56);
    #2 reset = 1'b0;
    #1 chk_irq("arst_irq", 1'b0);
    chk_rd("arst_tl", A_TL, 32'h0);
    chk_rd("arst_tcon", A_TCON, 32'h0);
    chk_rd("arst_tick", A_TICK, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // Bus decode
    wr(A_TL, 32'h100);
    chk_rd("dec_tl", A_TL, 32'h100);
    chk_rd("dec_miss_hi", 32'h5000_0004, 32'h0);
    chk_rd("dec_hole", BASE + 32'h10, 32'h0);
    wr(A_TICK, 32'h1234);
    probe(A_TICK);
    wr(32'h5000_0000, 32'hDEAD_BEEF);
    chk_rd("dec_th_miss", A_TH, 32'h0);
    wr(A_TCON, 32'hFFFF_FFFF);
    chk_rd("dec_tcon_mask", A_TCON, 32'h7);
    chk_irq("dec_irq", 1'b1);
    wr(A_TCON, 32'h0);
    chk_irq("dec_irq_clr", 1'b0);

    // Overflow with IE=0
    wr(A_TH, 32'h10);
    wr(A_TL, 32'hFFFF_FFFE);
    wr(A_TCON, 32'h1);
    cyc(); chk_rd("noie_tl_ff", A_TL, 32'hFFFF_FFFF);
    cyc(); chk_rd("noie_tl_rl", A_TL, 32'h10);
    chk_rd("noie_tcon", A_TCON, 32'h1);
    chk_irq("noie_irq", 1'b0);

    // Prescaler
    wr(A_TCON, 32'h0);
    wr(A_PSC, 32'h3);
    wr(A_TL, 32'h0);
    wr(A_TCON, 32'h1);
`ifdef TIMER_PRESCALE_EN
    cyc(); cyc(); cyc();
    chk_rd("psc_tl_e3", A_TL, 32'h0);
    cyc(); chk_rd("psc_tl_e4", A_TL, 32'h1);
    cyc(); cyc(); cyc(); cyc();
    chk_rd("psc_tl_e8", A_TL, 32'h2);
    chk_rd("psc_rd", A_PSC, 32'h3);
`else
    chk_rd("psc_absent", A_PSC, 32'h0);
    cyc(); chk_rd("nopsc_tl_e1", A_TL, 32'h1);
    cyc(); chk_rd("nopsc_tl_e2", A_TL, 32'h2);
`endif

    cyc(); cyc();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
